// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared types and constants for the ALU divider
package alu_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_q
);

    logic [WIDTH:0] shifted;
    logic           borrow;

    always_comb begin
        shifted = {rem, q[WIDTH-1]};
        borrow  = shifted < {1'b0, divisor};
        // When no borrow the difference is below divisor, so WIDTH bits hold it exactly.
        next_rem = borrow ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - divisor);
        next_q   = {q[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/abs_divider.sv
// rtl/abs_divider.sv - multi-cycle signed divider fed by magnitude operands
module abs_divider
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend_abs,
    input  logic [WIDTH-1:0] divisor_abs,
    input  logic             dividend_neg,
    input  logic             divisor_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] divisor_r;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             div0;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .q        (q_r),
        .divisor  (divisor_r),
        .next_rem (next_rem),
        .next_q   (next_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            divisor_r   <= '0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            div0        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_neg   <= dividend_neg;
                        dvs_neg   <= divisor_neg;
                        divisor_r <= divisor_abs;
                        q_r       <= dividend_abs;
                        cnt       <= '0;
                        in_ready  <= 1'b0;
                        // Zero divisor skips the iteration; FIX restores the dividend as remainder.
                        if (divisor_abs == '0) begin
                            rem_r <= dividend_abs;
                            div0  <= 1'b1;
                            state <= FIX;
                        end else begin
                            rem_r <= '0;
                            div0  <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_r <= next_rem;
                    q_r   <= next_q;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div0) begin
                        quotient    <= WIDTH'(DIV0_QUOTIENT);
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= (dvd_neg ^ dvs_neg) ? (~q_r + WIDTH'(1)) : q_r;
                        div_by_zero <= 1'b0;
                    end
                    remainder <= dvd_neg ? (~rem_r + WIDTH'(1)) : rem_r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abs_divider.sv
// tb/tb_abs_divider.sv - directed scoreboard bench for abs_divider
module tb_abs_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic        dividend_neg;
    logic        divisor_neg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    abs_divider dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dividend_abs (dividend_abs),
        .divisor_abs  (divisor_abs),
        .dividend_neg (dividend_neg),
        .divisor_neg  (divisor_neg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic dn, input logic sn,
                        input bit push, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input int el);
        @(negedge clk);
        dividend_abs = a;
        divisor_abs  = b;
        dividend_neg = dn;
        divisor_neg  = sn;
        in_valid     = 1'b1;
        check("in_ready_at_send", {63'd0, in_ready}, 64'd1);
        if (push) sb.push_back('{eq, er, ez, el});
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        dividend_abs = 32'hDEAD_BEEF;
        divisor_abs  = 32'h0BAD_F00D;
    endtask

    task automatic collect(input string tag, input bit release_now);
        exp_t e;
        int   lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_sb_nonempty"}, {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_quotient"}, {32'd0, quotient}, {32'd0, e.q});
            check({tag, "_remainder"}, {32'd0, remainder}, {32'd0, e.r});
            check({tag, "_div_by_zero"}, {63'd0, div_by_zero}, {63'd0, e.dz});
            check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        end
        if (release_now) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, "_released_valid"}, {63'd0, out_valid}, 64'd0);
            check({tag, "_released_ready"}, {63'd0, in_ready}, 64'd1);
        end
    endtask

    initial begin
        logic [31:0] held_q;
        logic [31:0] held_r;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend_abs = '0;
        divisor_abs = '0;
        dividend_neg = 1'b0;
        divisor_neg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_quotient", {32'd0, quotient}, 64'd0);
        check("reset_remainder", {32'd0, remainder}, 64'd0);
        check("reset_div_by_zero", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        send(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 32'd14, 32'd2, 1'b0, 33);
        collect("u100_7", 1'b1);

        send(32'd15, 32'd4, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 33);
        collect("n15_4", 1'b1);

        send(32'd15, 32'd4, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd3, 1'b0, 33);
        collect("p15_n4", 1'b1);

        send(32'd15, 32'd4, 1'b1, 1'b1, 1'b1, 32'd3, 32'hFFFF_FFFD, 1'b0, 33);
        collect("n15_n4", 1'b1);

        send(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
        collect("div0", 1'b1);

        send(32'd7, 32'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1);
        collect("div0_neg", 1'b1);

        // Backpressure: hold the result while junk operands are offered.
        send(32'd50, 32'd5, 1'b0, 1'b0, 1'b1, 32'd10, 32'd0, 1'b0, 33);
        collect("bp", 1'b0);
        held_q = quotient;
        held_r = remainder;
        @(negedge clk);
        in_valid = 1'b1;
        dividend_abs = 32'd9;
        divisor_abs = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_hold_quotient", {32'd0, quotient}, {32'd0, held_q});
            check("bp_hold_remainder", {32'd0, remainder}, {32'd0, held_r});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("bp_no_bypass_valid", {63'd0, out_valid}, 64'd0);
        check("bp_no_bypass_ready", {63'd0, in_ready}, 64'd1);

        send(32'd1000, 32'd33, 1'b0, 1'b0, 1'b1, 32'd30, 32'd10, 1'b0, 33);
        collect("after_bp", 1'b1);

        // Abort mid-iteration: no result may appear.
        send(32'd12345, 32'd11, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_quotient", {32'd0, quotient}, 64'd0);
        check("abort_remainder", {32'd0, remainder}, 64'd0);
        check("abort_div_by_zero", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        send(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
        collect("min_by_one", 1'b1);

        send(32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
        collect("min_by_neg1", 1'b1);

        send(32'd3, 32'd5, 1'b1, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFD, 1'b0, 33);
        collect("small_neg", 1'b1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
